// File: rtl/spi_slave_pkg.sv
// ============================================================================
// Module      : spi_slave_pkg
// Description : Shared defaults and helpers for the receive-only SPI slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_slave_pkg;

   localparam int DATA_W_DEF      = 8;
   localparam int SYNC_STAGES_DEF = 2;

   // Bit-counter width; never below one bit so degenerate widths still elaborate.
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/spi_sync.sv
// ============================================================================
// Module      : spi_sync
// Description : N-flop synchroniser for one asynchronous pin, reset to the
//               pin's idle level.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_chain;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_chain <= {STAGES{RST_VAL}};
      end else begin
         r_chain <= {r_chain[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/spi_slave.sv
// ============================================================================
// Module      : spi_slave
// Description : Receive-only SPI mode-0 slave; synchronises SCK/MOSI/CS and
//               deserialises DATA_W-bit words with a one-cycle done strobe.
//               Define SPI_SLAVE_LSB_FIRST_EN for LSB-first reception.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_slave
   import spi_slave_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_sck,
   input  logic              i_mosi,
   input  logic              i_cs,
   output logic [DATA_W-1:0] o_data,
   output logic              o_done
);

   localparam int              CNT_W  = cnt_width(DATA_W);
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DATA_W - 1);

   logic              w_sck;
   logic              w_mosi;
   logic              w_cs;
   logic              w_sck_rise;
   logic [DATA_W-1:0] w_next;

   logic              r_sck_prev;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_shift;
   logic [DATA_W-1:0] r_data;
   logic              r_done;

   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
      .i_clk(i_clk), .i_rst(i_rst), .i_d(i_sck),  .o_q(w_sck)
   );
   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .i_clk(i_clk), .i_rst(i_rst), .i_d(i_mosi), .o_q(w_mosi)
   );
   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .i_clk(i_clk), .i_rst(i_rst), .i_d(i_cs),   .o_q(w_cs)
   );

   assign w_sck_rise = w_sck & ~r_sck_prev;

`ifdef SPI_SLAVE_LSB_FIRST_EN
   assign w_next = {w_mosi, r_shift[DATA_W-1:1]};
`else
   assign w_next = {r_shift[DATA_W-2:0], w_mosi};
`endif

   // CS high takes priority over a coincident SCK rise, discarding the word.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sck_prev <= 1'b0;
         r_cnt      <= '0;
         r_shift    <= '0;
         r_data     <= '0;
         r_done     <= 1'b0;
      end else begin
         r_sck_prev <= w_sck;
         r_done     <= 1'b0;
         if (w_cs) begin
            r_cnt   <= '0;
            r_shift <= '0;
         end else if (w_sck_rise) begin
            r_shift <= w_next;
            if (r_cnt == C_LAST) begin
               r_cnt  <= '0;
               r_data <= w_next;
               r_done <= 1'b1;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
      end
   end

   assign o_data = r_data;
   assign o_done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave.sv
// ============================================================================
// Module      : tb_spi_slave
// Description : Directed self-checking bench for spi_slave with a scoreboard
//               of expected words popped on each done strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_slave;

   logic       clk  = 1'b0;
   logic       rst  = 1'b1;
   logic       sck  = 1'b0;
   logic       mosi = 1'b0;
   logic       cs   = 1'b1;
   logic [7:0] data;
   logic       done;

   int n_vec  = 0;
   int n_err  = 0;
   int n_done = 0;
   int n_push = 0;
   logic       prev_done = 1'b0;
   logic [7:0] sq[$];
   logic [7:0] exp_word;

   spi_slave dut (
      .i_clk (clk),
      .i_rst (rst),
      .i_sck (sck),
      .i_mosi(mosi),
      .i_cs  (cs),
      .o_data(data),
      .o_done(done)
   );

   always #10 clk = ~clk;

   // Master sends MSB first on the wire; the LSB-first build reverses it.
   function automatic logic [7:0] expv(input logic [7:0] v);
`ifdef SPI_SLAVE_LSB_FIRST_EN
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = v[7-i];
      return r;
`else
      return v;
`endif
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      sck  = 1'b0;
      mosi = b;
      tick(12);
      sck  = 1'b1;
      tick(13);
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 7; i >= 1; i--) send_bit(v[i]);
      sq.push_back(expv(v));
      n_push++;
      send_bit(v[0]);
   endtask

   task automatic start_frame();
      cs = 1'b0;
      tick(6);
   endtask

   task automatic end_frame();
      sck = 1'b0;
      tick(12);
      cs = 1'b1;
      tick(12);
   endtask

   // Scoreboard monitor: every strobe must match the oldest expected word.
   always @(negedge clk) begin
      if (done) begin
         n_done++;
         n_vec++;
         if (sq.size() == 0) begin
            n_err++;
            $error("FAIL unexpected_done: observed data=%02h, required no strobe", data);
         end else begin
            exp_word = sq.pop_front();
            assert (data === exp_word) else begin
               n_err++;
               $error("FAIL sb_data: observed %02h, required %02h", data, exp_word);
            end
         end
         n_vec++;
         assert (prev_done === 1'b0) else begin
            n_err++;
            $error("FAIL strobe_width: observed done high 2 cycles, required 1");
         end
      end
      prev_done <= done;
   end

   initial begin
      // Reset
      tick(3);
      rst = 1'b0;
      tick(1);
      n_vec++;
      assert (data === 8'h00) else begin
         n_err++; $error("FAIL rst_data: observed %02h, required 00", data);
      end
      n_vec++;
      assert (done === 1'b0) else begin
         n_err++; $error("FAIL rst_done: observed %b, required 0", done);
      end

      // SCK toggling with CS high
      for (int i = 0; i < 8; i++) send_bit(1'b1);
      sck = 1'b0;
      tick(10);
      n_vec++;
      assert (n_done === 0) else begin
         n_err++; $error("FAIL cs_high_sck: observed %0d strobes, required 0", n_done);
      end

      // Single byte 0x55 with latency check on the final rise
      start_frame();
      for (int i = 7; i >= 1; i--) send_bit(i[0] ? 1'b0 : 1'b1);
      sck  = 1'b0;
      mosi = 1'b1;
      tick(12);
      sq.push_back(expv(8'h55));
      n_push++;
      sck = 1'b1;
      tick(1);
      n_vec++;
      assert (done === 1'b0) else begin
         n_err++; $error("FAIL lat_edge1: observed %b, required 0", done);
      end
      tick(1);
      n_vec++;
      assert (done === 1'b0) else begin
         n_err++; $error("FAIL lat_edge2: observed %b, required 0", done);
      end
      tick(1);
      n_vec++;
      assert (done === 1'b1) else begin
         n_err++; $error("FAIL lat_edge3: observed %b, required 1", done);
      end
      tick(10);
      end_frame();
      n_vec++;
      assert (data === expv(8'h55)) else begin
         n_err++; $error("FAIL byte_55: observed %02h, required %02h", data, expv(8'h55));
      end

      // Abort after 5 bits, then 0xA3
      start_frame();
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      end_frame();
      n_vec++;
      assert (data === expv(8'h55)) else begin
         n_err++; $error("FAIL abort_hold: observed %02h, required %02h", data, expv(8'h55));
      end
      start_frame();
      send_byte(8'hA3);
      end_frame();
      n_vec++;
      assert (data === expv(8'hA3)) else begin
         n_err++; $error("FAIL byte_a3: observed %02h, required %02h", data, expv(8'hA3));
      end

      // Back-to-back 0xFF, 0x00 under one CS
      start_frame();
      send_byte(8'hFF);
      n_vec++;
      assert (data === 8'hFF) else begin
         n_err++; $error("FAIL b2b_ff: observed %02h, required ff", data);
      end
      send_byte(8'h00);
      end_frame();
      n_vec++;
      assert (data === 8'h00) else begin
         n_err++; $error("FAIL b2b_00: observed %02h, required 00", data);
      end

      // Trailing 9th bit discarded, then 0x3C
      start_frame();
      send_byte(8'h5A);
      send_bit(1'b1);
      end_frame();
      n_vec++;
      assert (data === expv(8'h5A)) else begin
         n_err++; $error("FAIL trail_5a: observed %02h, required %02h", data, expv(8'h5A));
      end
      start_frame();
      send_byte(8'h3C);
      end_frame();
      n_vec++;
      assert (data === expv(8'h3C)) else begin
         n_err++; $error("FAIL byte_3c: observed %02h, required %02h", data, expv(8'h3C));
      end

      // Mid-word reset, then 0x81
      start_frame();
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      sck = 1'b0;
      tick(3);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      n_vec++;
      assert (data === 8'h00) else begin
         n_err++; $error("FAIL midrst_data: observed %02h, required 00", data);
      end
      n_vec++;
      assert (done === 1'b0) else begin
         n_err++; $error("FAIL midrst_done: observed %b, required 0", done);
      end
      end_frame();
      start_frame();
      send_byte(8'h81);
      end_frame();
      n_vec++;
      assert (data === expv(8'h81)) else begin
         n_err++; $error("FAIL byte_81: observed %02h, required %02h", data, expv(8'h81));
      end

      // Bits 1,0,0,0,0,0,0,0: 0x80 MSB-first, 0x01 LSB-first
      start_frame();
      send_byte(8'h80);
      end_frame();
      n_vec++;
`ifdef SPI_SLAVE_LSB_FIRST_EN
      assert (data === 8'h01) else begin
         n_err++; $error("FAIL order: observed %02h, required 01", data);
      end
`else
      assert (data === 8'h80) else begin
         n_err++; $error("FAIL order: observed %02h, required 80", data);
      end
`endif

      // Totals
      tick(5);
      n_vec++;
      assert (n_done === n_push) else begin
         n_err++; $error("FAIL done_count: observed %0d, required %0d", n_done, n_push);
      end
      n_vec++;
      assert (sq.size() === 0) else begin
         n_err++; $error("FAIL sb_leftover: observed %0d pending, required 0", sq.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
